// File: rtl/ieu_alu_pipe_if.sv
// Issue / CDB bundle between the integer reservation station, the integer
// execution unit and the common data bus arbiter.
//   slave  : execution unit side (consumes issue, produces CDB request)
//   master : reservation station / arbiter side
interface ieu_alu_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
);
  logic                  i_flush;
  logic                  i_valid;
  logic [6:0]            i_opcode;
  logic [ADDR_WIDTH-1:0] i_iaddr;
  logic [DATA_WIDTH-1:0] i_insn;
  logic [DATA_WIDTH-1:0] i_src_a;
  logic [DATA_WIDTH-1:0] i_src_b;
  logic [TAG_WIDTH-1:0]  i_tag;
  logic                  o_stall;
  logic                  o_cdb_req;
  logic [DATA_WIDTH-1:0] o_cdb_data;
  logic [TAG_WIDTH-1:0]  o_cdb_tag;
  logic                  i_cdb_gnt;

  modport slave (
    input  i_flush, i_valid, i_opcode, i_iaddr, i_insn, i_src_a, i_src_b, i_tag,
    input  i_cdb_gnt,
    output o_stall, o_cdb_req, o_cdb_data, o_cdb_tag
  );

  modport master (
    output i_flush, i_valid, i_opcode, i_iaddr, i_insn, i_src_a, i_src_b, i_tag,
    output i_cdb_gnt,
    input  o_stall, o_cdb_req, o_cdb_data, o_cdb_tag
  );
endinterface

// File: rtl/ieu_alu_pipe.sv
// Integer execution unit: RV32I ALU stage (R1) feeding a result queue that
// arbitrates for the CDB, with credit-based stall back to the reservation
// station. Optional feature macro: IEU_CDB_BYPASS_EN (R1 drives the CDB
// directly while the queue is empty).
module ieu_alu_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 6,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  ieu_alu_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned PW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic [6:0] {
    OPC_OP    = 7'b0110011,
    OPC_OPIMM = 7'b0010011,
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111
  } opcode_e;

  // ALU signals
  logic [ADDR_WIDTH-1:0] iaddr;
  logic [DATA_WIDTH-1:0] imm_i, upper, op_a, op_b, alu_res, sra_res, res;
  logic [SHW-1:0]        shamt;
  logic                  is_op, slt, sltu;
  logic                  unused_insn;

  // Pipeline / queue state
  logic                  r1_valid_q, r1_valid_d;
  logic [DATA_WIDTH-1:0] r1_data_q, r1_data_d;
  logic [TAG_WIDTH-1:0]  r1_tag_q, r1_tag_d;
  logic [DATA_WIDTH-1:0] q_data_q [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag_q  [QUEUE_DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d, occupancy;
  logic                  q_empty, stall, accept, bypass, pop, bypass_take, enq;

  assign iaddr       = bus.i_iaddr;
  assign unused_insn = ^bus.i_insn[11:0];

  // RV32I result for the op currently presented on the issue port
  always_comb begin
    is_op   = (bus.i_opcode == OPC_OP);
    imm_i   = {{(DATA_WIDTH-12){bus.i_insn[31]}}, bus.i_insn[31:20]};
    upper   = {bus.i_insn[DATA_WIDTH-1:12], 12'b0};
    op_a    = bus.i_src_a;
    op_b    = is_op ? bus.i_src_b : imm_i;
    shamt   = op_b[SHW-1:0];
    slt     = $signed(op_a) < $signed(op_b);
    sltu    = op_a < op_b;
    sra_res = $signed(op_a) >>> shamt;
    alu_res = '0;
    case (bus.i_insn[14:12])
      3'b000:  alu_res = (is_op && bus.i_insn[30]) ? op_a - op_b : op_a + op_b;
      3'b001:  alu_res = op_a << shamt;
      3'b010:  alu_res = {{(DATA_WIDTH-1){1'b0}}, slt};
      3'b011:  alu_res = {{(DATA_WIDTH-1){1'b0}}, sltu};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = bus.i_insn[30] ? sra_res : op_a >> shamt;
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
    res = '0;
    case (bus.i_opcode)
      OPC_OP, OPC_OPIMM: res = alu_res;
      OPC_LUI:           res = upper;
      OPC_AUIPC:         res = DATA_WIDTH'(iaddr) + upper;
      default:           res = '0;
    endcase
  end

`ifdef IEU_CDB_BYPASS_EN
  assign bypass = q_empty && r1_valid_q;
`else
  assign bypass = 1'b0;
`endif

  // Credit, handshake and queue bookkeeping
  always_comb begin
    q_empty     = (count_q == '0);
    occupancy   = count_q + CW'(r1_valid_q);
    stall       = (occupancy == CW'(QUEUE_DEPTH));
    accept      = bus.i_valid && !stall && !bus.i_flush;
    pop         = !q_empty && bus.i_cdb_gnt;
    // A bypassed R1 result that wins the grant never enters the queue
    bypass_take = bypass && bus.i_cdb_gnt;
    enq         = r1_valid_q && !bypass_take;
    r1_valid_d  = accept;
    r1_data_d   = res;
    r1_tag_d    = bus.i_tag;
    head_d      = pop ? head_q + PW'(1) : head_q;
    tail_d      = enq ? tail_q + PW'(1) : tail_q;
    count_d     = count_q + CW'(enq) - CW'(pop);
  end

  // R1 stage and queue pointers; flush and reset both empty the unit
  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) begin
      r1_valid_q <= 1'b0;
      r1_data_q  <= '0;
      r1_tag_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      r1_valid_q <= r1_valid_d;
      r1_data_q  <= r1_data_d;
      r1_tag_q   <= r1_tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (enq) begin
      q_data_q[tail_q] <= r1_data_q;
      q_tag_q[tail_q]  <= r1_tag_q;
    end
  end

  assign bus.o_stall    = stall;
  assign bus.o_cdb_req  = !q_empty || bypass;
  assign bus.o_cdb_data = bypass ? r1_data_q : (q_empty ? '0 : q_data_q[head_q]);
  assign bus.o_cdb_tag  = bypass ? r1_tag_q  : (q_empty ? '0 : q_tag_q[head_q]);
endmodule
